// File: rtl/quantize_tile_pp_if.sv
// Handshake and data bundle for the tile quantizer: fill stream in,
// per-tile scale vector out, quantized stream out.
interface quantize_tile_pp_if #(
  parameter int LANES_NUM = 16,
  parameter int FP_DATA_W = 32,
  parameter int FP_EXP_W  = 8,
  parameter int MAT_SIZE  = 16
);
  logic                           s_valid_i;
  logic                           s_ready_o;
  logic [LANES_NUM*FP_DATA_W-1:0] s_data_i;
  logic                           s_mode_i;
  logic                           scl_valid_o;
  logic                           scl_ready_i;
  logic [FP_EXP_W*MAT_SIZE-1:0]   exp_scale_o;
  logic                           scl_mode_o;
  logic                           m_valid_o;
  logic                           m_ready_i;
  logic [LANES_NUM*FP_DATA_W-1:0] m_data_o;
  logic                           m_last_o;

  // Quantizer side
  modport slave (
    input  s_valid_i, s_data_i, s_mode_i, scl_ready_i, m_ready_i,
    output s_ready_o, scl_valid_o, exp_scale_o, scl_mode_o,
           m_valid_o, m_data_o, m_last_o
  );

  // Producer/consumer side
  modport master (
    output s_valid_i, s_data_i, s_mode_i, scl_ready_i, m_ready_i,
    input  s_ready_o, scl_valid_o, exp_scale_o, scl_mode_o,
           m_valid_o, m_data_o, m_last_o
  );
endinterface

// File: rtl/quantize_tile_pp.sv
// Double-buffered block-floating-point tile quantizer. Each bank cycles
// through the states below; one bank fills while the other scales/emits.
//
// state     | meaning
// B_EMPTY   | bank free, next fill beat starts a new tile here
// B_FILLING | tile partially received, running maxima being built
// B_SCALE   | tile complete, scale vector offered on the scale channel
// B_EMIT    | scale accepted, quantized beats being streamed out
module quantize_tile_pp #(
  parameter int BIT_NUM   = 8,
  parameter int MAT_SIZE  = 16,
  parameter int FP_DATA_W = 32,
  parameter int FP_EXP_W  = 8,
  parameter int FP_MANT_W = 23,
  parameter int LANES_NUM = 16
) (
  input logic               clk,
  input logic               rst,
  quantize_tile_pp_if.slave bus
);
  localparam int ELEMS  = MAT_SIZE * MAT_SIZE;
  localparam int BEATS  = ELEMS / LANES_NUM;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int MAT_W  = (MAT_SIZE > 1) ? $clog2(MAT_SIZE) : 1;
  localparam logic [BEAT_W-1:0]    LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [FP_MANT_W+1:0] MAG_MAX   = (FP_MANT_W+2)'((1 << (BIT_NUM - 1)) - 1);

  if ((ELEMS % LANES_NUM) != 0 ||
      ((LANES_NUM % MAT_SIZE) != 0 && (MAT_SIZE % LANES_NUM) != 0)) begin : g_bad_lanes
    $fatal(1, "quantize_tile_pp: LANES_NUM incompatible with MAT_SIZE");
  end
  if (BIT_NUM < 3 || BIT_NUM > FP_MANT_W + 1) begin : g_bad_bits
    $fatal(1, "quantize_tile_pp: BIT_NUM out of range");
  end
  if (FP_DATA_W != 1 + FP_EXP_W + FP_MANT_W) begin : g_bad_fmt
    $fatal(1, "quantize_tile_pp: float field widths inconsistent");
  end

  typedef enum logic [1:0] {B_EMPTY, B_FILLING, B_SCALE, B_EMIT} bank_st_t;

  bank_st_t                       bank_st [2];
  logic                           fill_ptr, emit_ptr;
  logic [BEAT_W-1:0]              in_beat, out_beat;
  logic [LANES_NUM*FP_DATA_W-1:0] mem     [2][BEATS];
  logic [FP_EXP_W-1:0]            row_max [2][MAT_SIZE];
  logic [FP_EXP_W-1:0]            col_max [2][MAT_SIZE];
  logic                           bank_mode [2];
  logic [FP_EXP_W-1:0]            row_nx [MAT_SIZE];
  logic [FP_EXP_W-1:0]            col_nx [MAT_SIZE];
  logic [FP_EXP_W*MAT_SIZE-1:0]   scale_vec;
  logic                           s_ready, scl_valid, m_valid, emit_active;
  logic                           s_fire, scl_fire, m_fire;
  int                             idx_f, idx_e;
  logic [MAT_W-1:0]               r_f, c_f, r_e, c_e;
  logic [FP_EXP_W-1:0]            e_f, emax_e;

  // Element quantization against its axis maximum exponent.
  function automatic logic [FP_DATA_W-1:0] quant(input logic [FP_DATA_W-1:0] w,
                                                 input logic [FP_EXP_W-1:0]  emax);
    logic [FP_EXP_W-1:0]  e;
    logic [FP_MANT_W+1:0] sum;
    logic [FP_MANT_W+1:0] mag;
    logic [BIT_NUM-1:0]   q;
    int                   sh;
    e   = w[FP_DATA_W-2 -: FP_EXP_W];
    sh  = FP_MANT_W - (BIT_NUM - 2) + int'(emax) - int'(e);
    sum = '0;
    mag = '0;
    if (e != '0 && sh <= FP_MANT_W + 1) begin
      sum = {2'b01, w[FP_MANT_W-1:0]} + ((FP_MANT_W+2)'(1) << (sh - 1));
      mag = sum >> sh;
    end
    if (mag > MAG_MAX) mag = MAG_MAX;
    q = mag[BIT_NUM-1:0];
    if (w[FP_DATA_W-1]) q = -q;
    return {{(FP_DATA_W-BIT_NUM){q[BIT_NUM-1]}}, q};
  endfunction

  assign s_ready     = (bank_st[fill_ptr] == B_EMPTY) || (bank_st[fill_ptr] == B_FILLING);
  assign scl_valid   = (bank_st[emit_ptr] == B_SCALE);
  assign m_valid     = (bank_st[emit_ptr] == B_EMIT);
  assign emit_active = scl_valid || m_valid;
  assign s_fire      = bus.s_valid_i && s_ready;
  assign scl_fire    = scl_valid && bus.scl_ready_i;
  assign m_fire      = m_valid && bus.m_ready_i;

  assign bus.s_ready_o   = s_ready;
  assign bus.scl_valid_o = scl_valid;
  assign bus.m_valid_o   = m_valid;
  assign bus.m_last_o    = m_valid && (out_beat == LAST_BEAT);
  assign bus.scl_mode_o  = emit_active && bank_mode[emit_ptr];
  assign bus.exp_scale_o = scale_vec;

  // Next running maxima for the filling bank; beat 0 starts from zero so
  // nothing left over from the bank's previous tile leaks in.
  always_comb begin
    idx_f = 0;
    r_f   = '0;
    c_f   = '0;
    e_f   = '0;
    for (int k = 0; k < MAT_SIZE; k++) begin
      row_nx[MAT_W'(k)] = (in_beat == '0) ? '0 : row_max[fill_ptr][MAT_W'(k)];
      col_nx[MAT_W'(k)] = (in_beat == '0) ? '0 : col_max[fill_ptr][MAT_W'(k)];
    end
    for (int l = 0; l < LANES_NUM; l++) begin
      idx_f = int'(in_beat) * LANES_NUM + l;
      r_f   = MAT_W'(idx_f / MAT_SIZE);
      c_f   = MAT_W'(idx_f % MAT_SIZE);
      e_f   = bus.s_data_i[l*FP_DATA_W + FP_MANT_W +: FP_EXP_W];
      if (e_f > row_nx[r_f]) row_nx[r_f] = e_f;
      if (e_f > col_nx[c_f]) col_nx[c_f] = e_f;
    end
  end

  // Scale vector of the emitting bank, zero while nothing is offered.
  always_comb begin
    scale_vec = '0;
    for (int k = 0; k < MAT_SIZE; k++) begin
      if (emit_active)
        scale_vec[k*FP_EXP_W +: FP_EXP_W] = bank_mode[emit_ptr] ? col_max[emit_ptr][MAT_W'(k)]
                                                                : row_max[emit_ptr][MAT_W'(k)];
    end
  end

  // Quantized lanes of the current output beat; only registered state feeds
  // this, so it holds still across a stall.
  always_comb begin
    bus.m_data_o = '0;
    idx_e  = 0;
    r_e    = '0;
    c_e    = '0;
    emax_e = '0;
    for (int l = 0; l < LANES_NUM; l++) begin
      idx_e  = int'(out_beat) * LANES_NUM + l;
      r_e    = MAT_W'(idx_e / MAT_SIZE);
      c_e    = MAT_W'(idx_e % MAT_SIZE);
      emax_e = bank_mode[emit_ptr] ? col_max[emit_ptr][c_e] : row_max[emit_ptr][r_e];
      if (m_valid)
        bus.m_data_o[l*FP_DATA_W +: FP_DATA_W] =
          quant(mem[emit_ptr][out_beat][l*FP_DATA_W +: FP_DATA_W], emax_e);
    end
  end

  // Bank state machines, pointers and beat counters. Fill only ever touches
  // an EMPTY/FILLING bank and emit only a SCALE/EMIT bank, so the two never
  // collide on the same bank.
  always_ff @(posedge clk) begin
    if (rst) begin
      bank_st[0] <= B_EMPTY;
      bank_st[1] <= B_EMPTY;
      fill_ptr   <= 1'b0;
      emit_ptr   <= 1'b0;
      in_beat    <= '0;
      out_beat   <= '0;
    end else begin
      if (s_fire) begin
        if (in_beat == LAST_BEAT) begin
          bank_st[fill_ptr] <= B_SCALE;
          in_beat           <= '0;
          fill_ptr          <= ~fill_ptr;
        end else begin
          bank_st[fill_ptr] <= B_FILLING;
          in_beat           <= in_beat + 1'b1;
        end
      end
      if (scl_fire) bank_st[emit_ptr] <= B_EMIT;
      if (m_fire) begin
        if (out_beat == LAST_BEAT) begin
          bank_st[emit_ptr] <= B_EMPTY;
          out_beat          <= '0;
          emit_ptr          <= ~emit_ptr;
        end else begin
          out_beat <= out_beat + 1'b1;
        end
      end
    end
  end

  // Tile storage, running maxima and axis mode of the filling bank.
  always_ff @(posedge clk) begin
    if (s_fire) begin
      mem[fill_ptr][in_beat] <= bus.s_data_i;
      for (int k = 0; k < MAT_SIZE; k++) begin
        row_max[fill_ptr][MAT_W'(k)] <= row_nx[MAT_W'(k)];
        col_max[fill_ptr][MAT_W'(k)] <= col_nx[MAT_W'(k)];
      end
      if (in_beat == '0) bank_mode[fill_ptr] <= bus.s_mode_i;
    end
  end
endmodule
